// File: rtl/transducer_drive_if.sv
// Bundle between the phase source and the transducer drive generator.
// master: drives en/phase_valid/phase_in (and duty when DRIVE_GEN_DUTY_EN); slave: the generator.
interface transducer_drive_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int PHASE_W      = 8
);
    logic                            en;
    logic                            phase_valid;
    logic [NUM_CHANNELS*PHASE_W-1:0] phase_in;
`ifdef DRIVE_GEN_DUTY_EN
    logic [PHASE_W-1:0]              duty;
`endif
    logic [NUM_CHANNELS-1:0]         drive_out;
    logic                            sync_out;
    logic                            update_pending;

    modport master (
`ifdef DRIVE_GEN_DUTY_EN
        output duty,
`endif
        output en,
        output phase_valid,
        output phase_in,
        input  drive_out,
        input  sync_out,
        input  update_pending
    );

    modport slave (
`ifdef DRIVE_GEN_DUTY_EN
        input  duty,
`endif
        input  en,
        input  phase_valid,
        input  phase_in,
        output drive_out,
        output sync_out,
        output update_pending
    );
endinterface

// File: rtl/transducer_drive_gen.sv
// Phase-shifted square-wave generator for the ultrasonic transducer array.
// Ports: clk, rst_n (async, active low), bus (slave): en, phase_valid,
// phase_in -> drive_out, sync_out, update_pending.
// Optional macro DRIVE_GEN_DUTY_EN adds a double-buffered duty threshold.
module transducer_drive_gen #(
    parameter int NUM_CHANNELS = 4,
    parameter int PHASE_W      = 8,
    parameter int CLK_DIV      = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    transducer_drive_if.slave bus
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [PHASE_W-1:0] HALF = {1'b1, {(PHASE_W-1){1'b0}}};

    typedef logic [NUM_CHANNELS-1:0][PHASE_W-1:0] phase_vec_t;

    logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
    logic [PHASE_W-1:0]      carrier_q, carrier_d;
    logic                    sync_q, sync_d;
    logic                    pend_q, pend_d;
    phase_vec_t              shadow_q, shadow_d;
    phase_vec_t              active_q, active_d;
    phase_vec_t              phase_new;
    logic [NUM_CHANNELS-1:0] drive_q, drive_d;
    logic [PHASE_W-1:0]      thr;
    logic                    tick;
    logic                    wrap;

`ifdef DRIVE_GEN_DUTY_EN
    logic [PHASE_W-1:0]      sh_duty_q, sh_duty_d;
    logic [PHASE_W-1:0]      act_duty_q, act_duty_d;
    assign thr = act_duty_q;
`else
    assign thr = HALF;
`endif

    assign phase_new = bus.phase_in;
    assign tick      = (div_cnt_q == DIV_LAST);
    assign wrap      = bus.en && tick && (carrier_q == '1);

    always_comb begin
        logic [PHASE_W-1:0] diff;
        diff       = '0;
        div_cnt_d  = div_cnt_q;
        carrier_d  = carrier_q;
        sync_d     = 1'b0;
        pend_d     = pend_q;
        shadow_d   = shadow_q;
        active_d   = active_q;
        drive_d    = '0;
`ifdef DRIVE_GEN_DUTY_EN
        sh_duty_d  = sh_duty_q;
        act_duty_d = act_duty_q;
`endif
        if (bus.en) begin
            div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
            carrier_d = tick ? carrier_q + PHASE_W'(1) : carrier_q;
            sync_d    = wrap;
            // Commit the old shadow first so a coincident load
            // lands in the shadow and stays pending.
            if (wrap && pend_q) begin
                active_d   = shadow_q;
                pend_d     = 1'b0;
`ifdef DRIVE_GEN_DUTY_EN
                act_duty_d = sh_duty_q;
`endif
            end
            if (bus.phase_valid) begin
                shadow_d  = phase_new;
                pend_d    = 1'b1;
`ifdef DRIVE_GEN_DUTY_EN
                sh_duty_d = bus.duty;
`endif
            end
        end else begin
            div_cnt_d = '0;
            carrier_d = '0;
            pend_d    = 1'b0;
            // Outputs are idle, so updates apply at once.
            if (bus.phase_valid) begin
                shadow_d   = phase_new;
                active_d   = phase_new;
`ifdef DRIVE_GEN_DUTY_EN
                sh_duty_d  = bus.duty;
                act_duty_d = bus.duty;
`endif
            end else if (pend_q) begin
                active_d   = shadow_q;
`ifdef DRIVE_GEN_DUTY_EN
                act_duty_d = sh_duty_q;
`endif
            end
        end
        // Modular difference: wrap-around is what makes the
        // phase offset circular across the carrier period.
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            diff       = carrier_q - active_q[i];
            drive_d[i] = bus.en && (diff < thr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q  <= '0;
            carrier_q  <= '0;
            sync_q     <= 1'b0;
            pend_q     <= 1'b0;
            shadow_q   <= '0;
            active_q   <= '0;
            drive_q    <= '0;
`ifdef DRIVE_GEN_DUTY_EN
            sh_duty_q  <= HALF;
            act_duty_q <= HALF;
`endif
        end else begin
            div_cnt_q  <= div_cnt_d;
            carrier_q  <= carrier_d;
            sync_q     <= sync_d;
            pend_q     <= pend_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            drive_q    <= drive_d;
`ifdef DRIVE_GEN_DUTY_EN
            sh_duty_q  <= sh_duty_d;
            act_duty_q <= act_duty_d;
`endif
        end
    end

    assign bus.drive_out      = drive_q;
    assign bus.sync_out       = sync_q;
    assign bus.update_pending = pend_q;

endmodule

// File: tb/tb_transducer_drive_gen.sv
// Randomized self-checking bench for transducer_drive_gen with a
// cycle-level reference model plus directed timing measurements.
module tb_transducer_drive_gen;

    localparam int NCH = 4;
    localparam int PW  = 8;
    localparam int DIV = 5;
    localparam int PER = DIV * 256;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    transducer_drive_if #(.NUM_CHANNELS(NCH), .PHASE_W(PW)) bus ();

    transducer_drive_gen #(
        .NUM_CHANNELS(NCH),
        .PHASE_W(PW),
        .CLK_DIV(DIV)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: time-based view of the carrier (enabled
    // cycles / DIV), phase bank as plain integers.
    int       mn;
    int       mact[NCH];
    int       msh[NCH];
    bit       mpend;
    int       mact_duty;
    int       msh_duty;
    bit [3:0] edrive;
    bit       esync;
    int       mc;
    int       mthr;
    bit       mwrap;

    function automatic int mcar();
        return (mn / DIV) % 256;
    endfunction

    function automatic int pin(input int i);
        logic [NCH*PW-1:0] v;
        v = bus.phase_in;
        return int'(v[i*PW +: PW]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mn = 0; mpend = 0; edrive = '0; esync = 0;
            mact_duty = 128; msh_duty = 128;
            for (int i = 0; i < NCH; i++) begin
                mact[i] = 0; msh[i] = 0;
            end
        end else if (bus.en) begin
            mc    = mcar();
            mwrap = (mn % DIV == DIV - 1) && (mc == 255);
`ifdef DRIVE_GEN_DUTY_EN
            mthr = mact_duty;
`else
            mthr = 128;
`endif
            for (int i = 0; i < NCH; i++)
                edrive[i] = ((mc - mact[i] + 256) % 256) < mthr;
            esync = mwrap;
            if (mwrap && mpend) begin
                for (int i = 0; i < NCH; i++) mact[i] = msh[i];
                mact_duty = msh_duty;
                mpend = 0;
            end
            if (bus.phase_valid) begin
                for (int i = 0; i < NCH; i++) msh[i] = pin(i);
`ifdef DRIVE_GEN_DUTY_EN
                msh_duty = int'(bus.duty);
`endif
                mpend = 1;
            end
            mn++;
        end else begin
            mn = 0; edrive = '0; esync = 0;
            if (bus.phase_valid) begin
                for (int i = 0; i < NCH; i++) begin
                    msh[i] = pin(i); mact[i] = pin(i);
                end
`ifdef DRIVE_GEN_DUTY_EN
                msh_duty = int'(bus.duty); mact_duty = msh_duty;
`endif
            end else if (mpend) begin
                for (int i = 0; i < NCH; i++) mact[i] = msh[i];
                mact_duty = msh_duty;
            end
            mpend = 0;
        end
    end

    always @(negedge clk) begin
        check("m_drive", 32'(bus.drive_out), 32'(edrive));
        check("m_sync", 32'(bus.sync_out), 32'(esync));
        check("m_pend", 32'(bus.update_pending), 32'(mpend));
    end

    task automatic load(input logic [31:0] p);
        @(negedge clk);
        bus.phase_valid = 1'b1;
        bus.phase_in    = p;
        @(negedge clk);
        bus.phase_valid = 1'b0;
    endtask

    task automatic wait_car(input int c, input int ph);
        int k;
        k = 0;
        while (!(mcar() == c && (mn % DIV) == ph) && k < 3 * PER) begin
            @(negedge clk);
            k++;
        end
        check("reach_car", 32'(mcar()), 32'(c));
    endtask

    // en rises from idle; record edge timing relative to the
    // first clock after en is sampled.
    task automatic run_measure(input string tag);
        int  rise[NCH];
        bit  prev[NCH];
        int  sfirst;
        int  scnt;
        int  high0;
        int  t0;
        sfirst = -1; scnt = 0; high0 = 0; t0 = 0;
        for (int i = 0; i < NCH; i++) begin
            rise[i] = -1; prev[i] = 1'b0;
        end
        @(negedge clk);
        bus.en = 1'b1;
        for (int t = 0; t < 2 * PER + 40; t++) begin
            @(negedge clk);
            if (t == 0) t0 = int'(bus.drive_out[0]);
            if (t < PER && bus.drive_out[0]) high0++;
            if (bus.sync_out) begin
                scnt++;
                if (sfirst < 0) sfirst = t;
            end
            for (int i = 0; i < NCH; i++) begin
                if (t > 0 && !prev[i] && bus.drive_out[i] && rise[i] < 0)
                    rise[i] = t;
                prev[i] = bus.drive_out[i];
            end
        end
        check({tag, "_ch0_t0"}, 32'(t0), 1);
        check({tag, "_rise0"}, 32'(rise[0]), PER);
        check({tag, "_rise1"}, 32'(rise[1]), 64 * DIV);
        check({tag, "_rise2"}, 32'(rise[2]), 128 * DIV);
        check({tag, "_rise3"}, 32'(rise[3]), 192 * DIV);
        check({tag, "_high0"}, 32'(high0), PER / 2);
        check({tag, "_sync1"}, 32'(sfirst), PER - 1);
        check({tag, "_nsync"}, 32'(scnt), 2);
    endtask

    task automatic wait_sync(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.sync_out && k < 2 * PER);
    endtask

    initial begin
        int k;
        int lowp;
        int hc;
        checks = 0; errors = 0;
        rst_n = 1'b0;
        bus.en = 1'b0; bus.phase_valid = 1'b0; bus.phase_in = '0;
`ifdef DRIVE_GEN_DUTY_EN
        bus.duty = 8'd128;
`endif
        repeat (2) @(negedge clk);
        check("rst_drive", 32'(bus.drive_out), 0);
        check("rst_sync", 32'(bus.sync_out), 0);
        check("rst_pend", 32'(bus.update_pending), 0);
        rst_n = 1'b1;

        // Phases loaded while idle take effect immediately.
        load({8'd192, 8'd128, 8'd64, 8'd0});
        check("idle_pend", 32'(bus.update_pending), 0);
        run_measure("run1");

        // Asynchronous reset mid-period.
        repeat (37) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_drive", 32'(bus.drive_out), 0);
        check("arst_sync", 32'(bus.sync_out), 0);
        check("arst_pend", 32'(bus.update_pending), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_ch0", 32'(bus.drive_out[0]), 1);

        // Deferred update; ch0 rises 128 ticks plus the compare
        // register delay after the sync pulse.
        wait_car(10, 0);
        bus.phase_valid = 1'b1;
        bus.phase_in    = {8'd9, 8'd9, 8'd9, 8'd128};
        @(negedge clk);
        bus.phase_valid = 1'b0;
        check("def_pend", 32'(bus.update_pending), 1);
        wait_sync(k);
        check("def_sync_seen", 32'(bus.sync_out), 1);
        check("def_pend_clr", 32'(bus.update_pending), 0);
        k = 0;
        while (!bus.drive_out[0] && k < PER) begin
            @(negedge clk);
            k++;
        end
        check("def_rise", 32'(k), 128 * DIV + 1);

        // Load coincident with wrap while an update is pending.
        wait_car(40, 0);
        load({8'd0, 8'd0, 8'd0, 8'd64});
        wait_car(255, DIV - 1);
        bus.phase_valid = 1'b1;
        bus.phase_in    = {8'd1, 8'd2, 8'd3, 8'd32};
        @(negedge clk);
        bus.phase_valid = 1'b0;
        check("col_sync", 32'(bus.sync_out), 1);
        check("col_pend", 32'(bus.update_pending), 1);
        lowp = 0; k = 0;
        do begin
            @(negedge clk);
            k++;
            if (!bus.update_pending && !bus.sync_out) lowp++;
        end while (!bus.sync_out && k < 2 * PER);
        check("col_period", 32'(k), PER);
        check("col_pend_held", 32'(lowp), 0);
        check("col_pend_clr", 32'(bus.update_pending), 0);

        // Disable mid-period, then restart from carrier 0.
        wait_car(100, 2);
        bus.en = 1'b0;
        @(negedge clk);
        check("dis_drive", 32'(bus.drive_out), 0);
        check("dis_sync", 32'(bus.sync_out), 0);
        repeat (20) @(negedge clk);
        load({8'd192, 8'd128, 8'd64, 8'd0});
        run_measure("run2");

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            bus.phase_valid = ($urandom_range(0, 39) == 0);
            bus.phase_in    = $urandom;
`ifdef DRIVE_GEN_DUTY_EN
            bus.duty        = 8'($urandom);
`endif
            if (bus.en) begin
                if ($urandom_range(0, 299) == 0) bus.en = 1'b0;
            end else if ($urandom_range(0, 19) == 0) begin
                bus.en = 1'b1;
            end
        end
        @(negedge clk);
        bus.phase_valid = 1'b0;
        bus.en = 1'b0;

`ifdef DRIVE_GEN_DUTY_EN
        bus.duty = 8'd64;
        load('0);
        @(negedge clk);
        bus.en = 1'b1;
        hc = 0;
        for (int t = 0; t < PER; t++) begin
            @(negedge clk);
            if (bus.drive_out[0]) hc++;
        end
        check("duty64_high", 32'(hc), 64 * DIV);
        @(negedge clk);
        bus.en = 1'b0;
        bus.duty = 8'd0;
        load('0);
        @(negedge clk);
        bus.en = 1'b1;
        hc = 0;
        for (int t = 0; t < PER; t++) begin
            @(negedge clk);
            if (bus.drive_out[0]) hc++;
        end
        check("duty0_high", 32'(hc), 0);
`else
        hc = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
